// File: rtl/audio_i2s_tx_pkg.sv
// Shared audio constants for the I2S output path.
// Holds default widths, dividers and the frame-length consistency check.
package audio_i2s_tx_pkg;

    localparam int DEF_BITDEPTH        = 14;
    localparam int DEF_SLOT_BITS       = 16;
    localparam int DEF_BCLK_DIV        = 4;
    localparam int DEF_SAMPLECLOCK_DIV = 8;

    // One I2S frame must span exactly one sample_clock period.
    function automatic bit frame_len_ok(input int slot_bits,
                                        input int bclk_div,
                                        input int sc_div);
        return (4 * slot_bits * bclk_div) == (1 << sc_div);
    endfunction

endpackage

// File: rtl/audio_i2s_tx_bit_timer.sv
// I2S bit timer: BCLK divider, slot bit index k, BCLK/LRCK generation.
// Ports: clk_i, rst_i (sync, active high); bclk_o, lrck_o registered;
//        fall_o = BCLK falling-edge event, load_o = falling edge entering k=1.
module i2s_bit_timer #(
    parameter int SLOT_BITS = 16,
    parameter int BCLK_DIV  = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic bclk_o,
    output logic lrck_o,
    output logic fall_o,
    output logic load_o
);

    localparam int CW = $clog2(2 * BCLK_DIV);
    localparam int KW = $clog2(2 * SLOT_BITS);

    localparam logic [CW-1:0] CNT_MAX  = CW'(2 * BCLK_DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(BCLK_DIV);
    localparam logic [KW-1:0] K_MAX    = KW'(2 * SLOT_BITS - 1);
    localparam logic [KW-1:0] K_HALF   = KW'(SLOT_BITS);
    localparam logic [KW-1:0] K_ONE    = KW'(1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [KW-1:0] k_q, k_d;
    logic          bclk_q, lrck_q;
    logic          fall;

    always_comb begin
        fall  = (cnt_q == CNT_MAX);
        cnt_d = fall ? '0 : cnt_q + 1'b1;
        k_d   = k_q;
        if (fall) begin
            k_d = (k_q == K_MAX) ? '0 : k_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            k_q    <= '0;
            bclk_q <= 1'b0;
            lrck_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            k_q    <= k_d;
            // Outputs follow the next-state so they change on the event edge.
            bclk_q <= (cnt_d >= CNT_HALF);
            lrck_q <= (k_d >= K_HALF);
        end
    end

    assign bclk_o = bclk_q;
    assign lrck_o = lrck_q;
    assign fall_o = fall;
    assign load_o = fall && (k_d == K_ONE);

endmodule

// File: rtl/audio_i2s_tx.sv
// I2S transmitter: captures unsigned stereo samples and serialises them.
// Ports: clk, rst (sync, active high), sample_clock, in_l/in_r in;
//        i2s_bclk, i2s_lrck, i2s_sdata, frame_start, overrun (sticky) out.
module audio_i2s_tx
    import audio_i2s_tx_pkg::*;
#(
    parameter int BITDEPTH  = DEF_BITDEPTH,
    parameter int SLOT_BITS = DEF_SLOT_BITS,
    parameter int BCLK_DIV  = DEF_BCLK_DIV
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_clock,
    input  logic [BITDEPTH-1:0] in_l,
    input  logic [BITDEPTH-1:0] in_r,
    output logic                i2s_bclk,
    output logic                i2s_lrck,
    output logic                i2s_sdata,
    output logic                frame_start,
    output logic                overrun
);

    localparam int WW = 2 * SLOT_BITS;

    if (!frame_len_ok(SLOT_BITS, BCLK_DIV, DEF_SAMPLECLOCK_DIV) ||
        SLOT_BITS < BITDEPTH) begin : g_bad_cfg
        $error("audio_i2s_tx: inconsistent frame configuration");
    end

    // Offset binary -> two's complement, left aligned in the slot.
    function automatic logic [SLOT_BITS-1:0] conv(input logic [BITDEPTH-1:0] u);
        logic [SLOT_BITS-1:0] t;
        t = '0;
        t[SLOT_BITS-1 -: BITDEPTH] = {~u[BITDEPTH-1], u[BITDEPTH-2:0]};
        return t;
    endfunction

    logic          fall, load;
    logic          sc_q, strobe;
    logic [WW-1:0] word_in;
    logic [WW-1:0] hold_q, hold_d;
    logic [WW-1:0] shift_q, shift_d;
    logic          pend_q, pend_d;
    logic          ovr_q, ovr_d;
    logic          sdata_q, fs_q;

    i2s_bit_timer #(
        .SLOT_BITS (SLOT_BITS),
        .BCLK_DIV  (BCLK_DIV)
    ) u_timer (
        .clk_i  (clk),
        .rst_i  (rst),
        .bclk_o (i2s_bclk),
        .lrck_o (i2s_lrck),
        .fall_o (fall),
        .load_o (load)
    );

    assign strobe  = sample_clock & ~sc_q;
    assign word_in = {conv(in_l), conv(in_r)};

    always_comb begin
        hold_d  = hold_q;
        pend_d  = pend_q;
        ovr_d   = ovr_q;
        shift_d = shift_q;
        if (strobe) begin
            hold_d = word_in;
            pend_d = 1'b1;
            if (pend_q) begin
                ovr_d = 1'b1;
            end
        end
        if (load) begin
            // A sample arriving on the load cycle goes straight out.
            shift_d = strobe ? word_in : hold_q;
            pend_d  = 1'b0;
        end else if (fall) begin
            shift_d = shift_q << 1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sc_q    <= 1'b0;
            hold_q  <= '0;
            pend_q  <= 1'b0;
            ovr_q   <= 1'b0;
            shift_q <= '0;
            sdata_q <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            sc_q    <= sample_clock;
            hold_q  <= hold_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
            shift_q <= shift_d;
            fs_q    <= load;
            if (fall) begin
                sdata_q <= shift_d[WW-1];
            end
        end
    end

    assign i2s_sdata   = sdata_q;
    assign frame_start = fs_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Directed bench for audio_i2s_tx with an I2S receiver model.
// 8 MHz clk, free-running or hand-driven sample_clock.
`timescale 1ns/1ps
module tb_audio_i2s_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sc_en = 1'b0;
    logic        sc_man = 1'b0;
    logic [7:0]  div_q = 8'd0;
    logic        sample_clock;
    logic [13:0] in_l = 14'd0;
    logic [13:0] in_r = 14'd0;
    logic        i2s_bclk, i2s_lrck, i2s_sdata, frame_start, overrun;

    int n_chk = 0;
    int n_fail = 0;

    always #62.5 clk = ~clk;

    always @(posedge clk) div_q <= div_q + 8'd1;

    assign sample_clock = sc_en ? div_q[7] : sc_man;

    audio_i2s_tx dut (
        .clk          (clk),
        .rst          (rst),
        .sample_clock (sample_clock),
        .in_l         (in_l),
        .in_r         (in_r),
        .i2s_bclk     (i2s_bclk),
        .i2s_lrck     (i2s_lrck),
        .i2s_sdata    (i2s_sdata),
        .frame_start  (frame_start),
        .overrun      (overrun)
    );

    // Receiver model state
    int          cyc = 0;
    logic        bclk_p = 1'b0;
    logic        lrck_p = 1'b0;
    logic [15:0] sr = 16'd0;
    logic [15:0] rx_l = 16'd0;
    logic [15:0] rx_r = 16'd0;
    int          rx_l_cnt = 0;
    int          rx_r_cnt = 0;
    int          fs_cnt = 0;
    int          fall_cnt = 0;
    int          bclk_last = -1;
    int          bclk_per = 0;
    int          lrck_last = -1;
    int          lrck_per = 0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            bclk_p = 1'b0;
            lrck_p = 1'b0;
            sr = 16'd0;
            bclk_last = -1;
            lrck_last = -1;
        end else begin
            if (frame_start) fs_cnt++;
            if (!i2s_bclk && bclk_p) fall_cnt++;
            if (i2s_bclk && !bclk_p) begin
                if (bclk_last >= 0) bclk_per = cyc - bclk_last;
                bclk_last = cyc;
                sr = {sr[14:0], i2s_sdata};
                // Word select change: this bit is the previous word's LSB.
                if (i2s_lrck != lrck_p) begin
                    if (lrck_p) begin
                        rx_r = sr;
                        rx_r_cnt++;
                    end else begin
                        rx_l = sr;
                        rx_l_cnt++;
                    end
                    if (i2s_lrck) begin
                        if (lrck_last >= 0) lrck_per = cyc - lrck_last;
                        lrck_last = cyc;
                    end
                end
                lrck_p = i2s_lrck;
            end
            bclk_p = i2s_bclk;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_fs(input string tag);
        int  c0;
        logic ok;
        c0 = fs_cnt;
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            if (fs_cnt != c0) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    task automatic wait_rword(input string tag);
        int  c0;
        logic ok;
        c0 = rx_r_cnt;
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            if (rx_r_cnt != c0) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    task automatic wait_falls(input int n, input string tag);
        int  c0;
        logic ok;
        c0 = fall_cnt;
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            if (fall_cnt - c0 >= n) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    task automatic pulse();
        @(negedge clk);
        sc_man = 1'b1;
        repeat (3) @(negedge clk);
        sc_man = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk_outs_zero(input string tag);
        chk({tag, "_bclk"}, 32'(i2s_bclk), 32'd0);
        chk({tag, "_lrck"}, 32'(i2s_lrck), 32'd0);
        chk({tag, "_sdata"}, 32'(i2s_sdata), 32'd0);
        chk({tag, "_fs"}, 32'(frame_start), 32'd0);
        chk({tag, "_ovr"}, 32'(overrun), 32'd0);
    endtask

    initial begin
        #(125.0 * 60000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   c0;
        logic sd_or;

        // 1: reset state and clock periods
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk_outs_zero("rst");
        rst = 1'b0;
        repeat (600) @(posedge clk);
        @(negedge clk);
        chk("bclk_period", 32'(bclk_per), 32'd8);
        chk("lrck_period", 32'(lrck_per), 32'd256);

        // 2: full-scale extremes
        in_l = 14'h3FFF;
        in_r = 14'h0000;
        pulse();
        wait_fs("t2_fs");
        wait_rword("t2_rw");
        chk("t2_left", 32'(rx_l), 32'h7FFC);
        chk("t2_right", 32'(rx_r), 32'h8000);

        // 3: silence with free-running sample clock
        in_l = 14'h2000;
        in_r = 14'h2000;
        sc_en = 1'b1;
        wait_fs("t3_fs0");
        wait_fs("t3_fs1");
        wait_fs("t3_fs2");
        wait_rword("t3_rw");
        chk("t3_left", 32'(rx_l), 32'h0000);
        chk("t3_right", 32'(rx_r), 32'h0000);
        c0 = fs_cnt;
        repeat (1024) @(posedge clk);
        chk("t3_fs_rate", 32'(fs_cnt - c0), 32'd4);
        @(negedge clk);
        chk("t3_ovr", 32'(overrun), 32'd0);

        // 4: stalled sample clock resends the held word
        @(negedge clk);
        sc_en = 1'b0;
        wait_fs("t4_fs0");
        in_l = 14'h0001;
        in_r = 14'h3FFE;
        pulse();
        wait_fs("t4_fs1");
        for (int i = 0; i < 3; i++) begin
            wait_rword("t4_rw");
            chk("t4_left", 32'(rx_l), 32'h8004);
            chk("t4_right", 32'(rx_r), 32'h7FF8);
        end
        @(negedge clk);
        chk("t4_ovr", 32'(overrun), 32'd0);

        // 5: two strobes between loads -> newer wins, sticky overrun
        wait_fs("t5_fs0");
        in_l = 14'h1000;
        in_r = 14'h1000;
        pulse();
        chk("t5_ovr_a", 32'(overrun), 32'd0);
        in_l = 14'h3000;
        in_r = 14'h3000;
        pulse();
        chk("t5_ovr_b", 32'(overrun), 32'd1);
        wait_fs("t5_fs1");
        wait_rword("t5_rw");
        chk("t5_left", 32'(rx_l), 32'h4000);
        chk("t5_right", 32'(rx_r), 32'h4000);
        wait_rword("t5_rw2");
        @(negedge clk);
        chk("t5_ovr_sticky", 32'(overrun), 32'd1);

        // 6: reset mid-frame at k=17
        wait_fs("t6_fs");
        wait_falls(16, "t6_k17");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_outs_zero("t6_rst");
        @(negedge clk);
        rst = 1'b0;
        sd_or = 1'b0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            sd_or = sd_or | i2s_sdata;
            if (i == 0) chk("t6_lrck_k0", 32'(i2s_lrck), 32'd0);
            if (i == 100) chk("t6_lrck_left", 32'(i2s_lrck), 32'd0);
            if (i == 150) chk("t6_lrck_right", 32'(i2s_lrck), 32'd1);
        end
        chk("t6_sdata_zero", 32'(sd_or), 32'd0);
        wait_rword("t6_rw");
        chk("t6_left", 32'(rx_l), 32'h0000);
        chk("t6_right", 32'(rx_r), 32'h0000);
        chk("t6_ovr", 32'(overrun), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
